// File: rtl/if_prefetch_stage.sv
`timescale 1ns/1ps
// Instruction-fetch stage: runs the fetch PC ahead of decode through a small
// in-order prefetch FIFO and squashes in-flight responses after a redirect.
module if_prefetch_stage #(
  parameter int              XLEN       = 32,
  parameter int              FIFO_DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter logic [31:0]     NOP_INST   = 32'h0000_0013
) (
  input  logic            Clk,
  input  logic            Reset_n,
  input  logic            Redirect_valid_i,
  input  logic [XLEN-1:0] Redirect_target_i,
  input  logic            Stall_i,
  output logic            Imem_req_o,
  output logic [XLEN-1:0] Imem_addr_o,
  input  logic            Imem_gnt_i,
  input  logic            Imem_rvalid_i,
  input  logic [31:0]     Imem_rdata_i,
  output logic [31:0]     Instruction_o,
  output logic [XLEN-1:0] Inst_pc_o,
  output logic            Inst_valid_o,
  output logic [7:0]      IF_tracker
);

  localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int              PW      = $clog2(FIFO_DEPTH);
  localparam logic [CW:0]     DEPTH   = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [XLEN-1:0] target;

  logic [XLEN-1:0] pc_mem   [FIFO_DEPTH];
  logic [31:0]     inst_mem [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;

  logic [CW-1:0]   fcnt;
  logic [CW-1:0]   fcnt_nxt;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   outstanding_nxt;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     occupancy;

  logic            gnt_fire;
  logic            resp_fire;
  logic            push;
  logic            pop;

  assign target    = Redirect_target_i & ~XLEN'(3);
  assign occupancy = {1'b0, fcnt} + {1'b0, outstanding};

  // Slots in flight count against the FIFO so every granted response has room.
  assign Imem_req_o  = Reset_n && !Redirect_valid_i && (occupancy < DEPTH);
  assign Imem_addr_o = fetch_pc;

  assign gnt_fire  = Imem_req_o && Imem_gnt_i;
  assign resp_fire = Imem_rvalid_i && (outstanding != '0);
  assign push      = resp_fire && (drop_cnt == '0) && !Redirect_valid_i;
  assign pop       = !Stall_i && !Redirect_valid_i && (fcnt != '0);

  always_comb begin
    outstanding_nxt = outstanding;
    if (gnt_fire && !resp_fire) begin
      outstanding_nxt = outstanding + CW'(1);
    end else if (resp_fire && !gnt_fire) begin
      outstanding_nxt = outstanding - CW'(1);
    end
  end

  always_comb begin
    fcnt_nxt = fcnt;
    if (push && !pop) begin
      fcnt_nxt = fcnt + CW'(1);
    end else if (pop && !push) begin
      fcnt_nxt = fcnt - CW'(1);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset_n && push) begin
      pc_mem[wr_ptr]   <= resp_pc;
      inst_mem[wr_ptr] <= Imem_rdata_i;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      fetch_pc      <= RESET_PC;
      resp_pc       <= RESET_PC;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fcnt          <= '0;
      outstanding   <= '0;
      drop_cnt      <= '0;
      Instruction_o <= NOP_INST;
      Inst_pc_o     <= '0;
      Inst_valid_o  <= 1'b0;
      IF_tracker    <= '0;
    end else begin
      outstanding <= outstanding_nxt;
      if (Redirect_valid_i) begin
        // Everything still in flight now belongs to the old path.
        fetch_pc      <= target;
        resp_pc       <= target;
        wr_ptr        <= '0;
        rd_ptr        <= '0;
        fcnt          <= '0;
        drop_cnt      <= outstanding_nxt;
        Instruction_o <= NOP_INST;
        Inst_valid_o  <= 1'b0;
      end else begin
        fcnt <= fcnt_nxt;
        if (gnt_fire) begin
          fetch_pc <= fetch_pc + PC_STEP;
        end
        if (resp_fire) begin
          if (drop_cnt != '0) begin
            drop_cnt <= drop_cnt - CW'(1);
          end else begin
            resp_pc <= resp_pc + PC_STEP;
          end
        end
        if (push) begin
          wr_ptr <= wr_ptr + PW'(1);
        end
        if (pop) begin
          rd_ptr        <= rd_ptr + PW'(1);
          Instruction_o <= inst_mem[rd_ptr];
          Inst_pc_o     <= pc_mem[rd_ptr];
          Inst_valid_o  <= 1'b1;
          IF_tracker    <= IF_tracker + 8'd1;
        end else if (!Stall_i) begin
          Instruction_o <= NOP_INST;
          Inst_valid_o  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_if_prefetch_stage.sv
`timescale 1ns/1ps
// Directed bench for if_prefetch_stage: an in-order memory model with settable
// latency, a PC reference model for every issued instruction, and explicit checks.
module tb_if_prefetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        Clk;
  logic        Reset_n;
  logic        Redirect_valid_i;
  logic [31:0] Redirect_target_i;
  logic        Stall_i;
  logic        Imem_req_o;
  logic [31:0] Imem_addr_o;
  logic        Imem_gnt_i;
  logic        Imem_rvalid_i;
  logic [31:0] Imem_rdata_i;
  logic [31:0] Instruction_o;
  logic [31:0] Inst_pc_o;
  logic        Inst_valid_o;
  logic [7:0]  IF_tracker;

  int          checkCount = 0;
  int          errorCount = 0;

  int          cyc = 0;
  int          lat = 1;
  int          gcount = 0;
  bit          gntEn = 1'b1;
  bit          randGnt = 1'b0;
  bit          randRv = 1'b0;
  logic [31:0] mqAddr[$];
  int          mqDue[$];

  logic [31:0] expPc = 32'h0;
  logic [7:0]  expTrk = 8'h0;
  int          issueCount = 0;

  if_prefetch_stage #(
    .XLEN(32), .FIFO_DEPTH(4), .RESET_PC(32'h0), .NOP_INST(NOP)
  ) dut (
    .Clk(Clk),
    .Reset_n(Reset_n),
    .Redirect_valid_i(Redirect_valid_i),
    .Redirect_target_i(Redirect_target_i),
    .Stall_i(Stall_i),
    .Imem_req_o(Imem_req_o),
    .Imem_addr_o(Imem_addr_o),
    .Imem_gnt_i(Imem_gnt_i),
    .Imem_rvalid_i(Imem_rvalid_i),
    .Imem_rdata_i(Imem_rdata_i),
    .Instruction_o(Instruction_o),
    .Inst_pc_o(Inst_pc_o),
    .Inst_valid_o(Inst_valid_o),
    .IF_tracker(IF_tracker)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic rstN, input logic stall, input logic redir, input logic [31:0] tgt);
    @(negedge Clk);
    Reset_n           = rstN;
    Stall_i           = stall;
    Redirect_valid_i  = redir;
    Redirect_target_i = tgt;
    #1;
  endtask

  task automatic runCycles(input int n);
    repeat (n) applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic waitFirstValid(input string tag, input logic [31:0] pc);
    int n = 0;
    while (!Inst_valid_o && n < 40) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput({tag, "_seen"}, 32'(Inst_valid_o), 32'd1);
    checkOutput(tag, Inst_pc_o, pc);
  endtask

  task automatic waitQueueSize(input string tag, input int size);
    int n = 0;
    while (mqAddr.size() != size && n < 40) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      n++;
    end
    checkOutput(tag, 32'(mqAddr.size()), 32'(size));
  endtask

  // In-order memory: response data is the bitwise complement of the address.
  initial begin
    bit          grantNow;
    bit          respNow;
    logic [31:0] grantAddr;
    Imem_gnt_i    = 1'b0;
    Imem_rvalid_i = 1'b0;
    Imem_rdata_i  = 32'h0;
    forever begin
      @(negedge Clk);
      Imem_gnt_i = gntEn && (!randGnt || ($urandom_range(0, 1) == 1));
      if (mqAddr.size() != 0 && mqDue[0] <= cyc && (!randRv || $urandom_range(0, 2) != 0)) begin
        Imem_rvalid_i = 1'b1;
        Imem_rdata_i  = ~mqAddr[0];
      end else begin
        Imem_rvalid_i = 1'b0;
        Imem_rdata_i  = 32'hDEAD_BEEF;
      end
      #2;
      grantNow  = Imem_req_o && Imem_gnt_i;
      grantAddr = Imem_addr_o;
      respNow   = Imem_rvalid_i;
      @(posedge Clk);
      cyc++;
      if (respNow && mqAddr.size() != 0) begin
        mqAddr.delete(0);
        mqDue.delete(0);
      end
      if (grantNow) begin
        mqAddr.push_back(grantAddr);
        mqDue.push_back(cyc + lat - 1);
        gcount++;
      end
    end
  end

  // Every newly issued instruction must be the next PC of the current path.
  initial begin
    logic mRst, mSt, mRd;
    forever begin
      @(posedge Clk);
      mRst = Reset_n;
      mSt  = Stall_i;
      mRd  = Redirect_valid_i;
      #2;
      if (mRst === 1'b1 && mRd) begin
        checkOutput("redir_bubble", 32'(Inst_valid_o), 32'd0);
      end else if (mRst === 1'b1 && !mSt && Inst_valid_o) begin
        checkOutput("pc", Inst_pc_o, expPc);
        checkOutput("inst", Instruction_o, ~expPc);
        expPc  = expPc + 32'd4;
        expTrk = expTrk + 8'd1;
        checkOutput("trk", 32'(IF_tracker), 32'(expTrk));
        issueCount++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          g0;
    int          i0;
    int          maxQ;
    logic [31:0] pcHold;
    logic [7:0]  trkHold;
    logic        st, rd;
    logic [31:0] tgt;

    Reset_n = 1'b0; Stall_i = 1'b0; Redirect_valid_i = 1'b0; Redirect_target_i = 32'h0;

    // Reset values
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("rst_req", 32'(Imem_req_o), 32'd0);
    checkOutput("rst_valid", 32'(Inst_valid_o), 32'd0);
    checkOutput("rst_inst", Instruction_o, NOP);
    checkOutput("rst_pc", Inst_pc_o, 32'h0);
    checkOutput("rst_trk", 32'(IF_tracker), 32'd0);

    // First fetch and pipeline latency with 1-cycle memory
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("first_req", 32'(Imem_req_o), 32'd1);
    checkOutput("first_addr", Imem_addr_o, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lat_c1", 32'(Inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lat_c2", 32'(Inst_valid_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("lat_c3", 32'(Inst_valid_o), 32'd1);
    checkOutput("first_pc", Inst_pc_o, 32'h0);
    checkOutput("first_trk", 32'(IF_tracker), 32'd1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("second_pc", Inst_pc_o, 32'h4);
    checkOutput("second_trk", 32'(IF_tracker), 32'd2);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("third_pc", Inst_pc_o, 32'h8);
    checkOutput("third_trk", 32'(IF_tracker), 32'd3);
    i0 = issueCount;
    runCycles(10);
    checkOutput("throughput", 32'(issueCount - i0), 32'd10);

    // Ten stalled cycles fill the FIFO then stop requesting
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    g0 = gcount; pcHold = Inst_pc_o; trkHold = IF_tracker;
    repeat (9) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("stall_gnts", 32'(gcount - g0), 32'd2);
    checkOutput("stall_req_off", 32'(Imem_req_o), 32'd0);
    checkOutput("stall_hold_pc", Inst_pc_o, pcHold);
    checkOutput("stall_hold_valid", 32'(Inst_valid_o), 32'd1);
    checkOutput("stall_hold_trk", 32'(IF_tracker), 32'(trkHold));
    i0 = issueCount;
    runCycles(8);
    checkOutput("stall_release_burst", 32'(issueCount - i0), 32'd8);

    // Redirect with three requests in flight, 3-cycle memory
    lat = 3;
    runCycles(6);
    waitQueueSize("outst3_reached", 3);
    applyStimulus(1'b1, 1'b0, 1'b1, 32'h103);
    expPc = 32'h100;
    checkOutput("redir_req_off", 32'(Imem_req_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("redir_addr", Imem_addr_o, 32'h100);
    checkOutput("redir_req_on", 32'(Imem_req_o), 32'd1);
    checkOutput("redir_inst_nop", Instruction_o, NOP);
    waitFirstValid("redir_first", 32'h100);
    runCycles(10);

    // Redirect while stalled with entries buffered
    lat = 1;
    runCycles(15);
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    trkHold = IF_tracker;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'h200);
    expPc = 32'h200;
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rs_valid", 32'(Inst_valid_o), 32'd0);
    checkOutput("rs_inst", Instruction_o, NOP);
    checkOutput("rs_trk", 32'(IF_tracker), 32'(trkHold));
    repeat (2) applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("rs_still_bubble", 32'(Inst_valid_o), 32'd0);
    waitFirstValid("rs_first", 32'h200);
    checkOutput("rs_trk_next", 32'(IF_tracker), 32'(trkHold + 8'd1));

    // Random grant/response gaps, stalls and redirects; tracker wraps past 255
    randGnt = 1'b1; randRv = 1'b1; maxQ = 0;
    for (int i = 0; i < 1000; i++) begin
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 39) == 0);
      tgt = 32'($urandom_range(0, 4095));
      applyStimulus(1'b1, st, rd, tgt);
      if (rd) expPc = tgt & ~32'd3;
      if (mqAddr.size() > maxQ) maxQ = mqAddr.size();
    end
    randGnt = 1'b0; randRv = 1'b0;
    runCycles(20);
    checkOutput("max_outst", 32'(maxQ <= 4), 32'd1);

    // Reset with two requests in flight; late responses must be ignored
    lat = 3;
    runCycles(4);
    waitQueueSize("outst3_pre_rst", 3);
    gntEn = 1'b0;
    waitQueueSize("outst2_pre_rst", 2);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    expPc = 32'h0; expTrk = 8'h0;
    checkOutput("mid_rst_req", 32'(Imem_req_o), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("mid_rst_valid", 32'(Inst_valid_o), 32'd0);
    checkOutput("mid_rst_inst", Instruction_o, NOP);
    checkOutput("mid_rst_pc", Inst_pc_o, 32'h0);
    checkOutput("mid_rst_trk", 32'(IF_tracker), 32'd0);
    checkOutput("mid_rst_addr", Imem_addr_o, 32'h0);
    runCycles(5);
    checkOutput("late_resp_ignored", 32'(Inst_valid_o), 32'd0);
    checkOutput("late_resp_req", 32'(Imem_req_o), 32'd1);
    gntEn = 1'b1;
    waitFirstValid("post_rst_first", 32'h0);
    checkOutput("post_rst_trk", 32'(IF_tracker), 32'd1);
    runCycles(5);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/if_prefetch_stage.md
# if_prefetch_stage

Parametrised instruction-fetch stage with a decoupled memory request/response interface and an in-order prefetch FIFO. It runs the fetch PC ahead of decode, keeps up to `FIFO_DEPTH` instructions buffered or in flight, and discards stale responses after a branch or jump redirect. It sits between instruction memory and the ID stage, and presents one registered instruction plus its PC per cycle.

## Interface
- `XLEN`, 32: PC and address width.
- `FIFO_DEPTH`, 4: prefetch entries; must be a power of 2 and at least 2.
- `RESET_PC`, 0: fetch PC loaded by reset.
- `NOP_INST`, 32'h00000013: instruction word injected on bubbles.

Clock and reset are decided: one clock; reset is synchronous and active-low.

- `Clk`  in  1  clock; all state updates on the rising edge.
- `Reset_n`  in  1  synchronous reset, active-low.
- `Redirect_valid_i`  in  1  branch taken or jump resolved this cycle.
- `Redirect_target_i`  in  XLEN  new PC; bits [1:0] are forced to 0.
- `Stall_i`  in  1  ID cannot accept; hold the output register.
- `Imem_req_o`  out  1  fetch request.
- `Imem_addr_o`  out  XLEN  request address, equal to the fetch PC.
- `Imem_gnt_i`  in  1  request accepted this cycle.
- `Imem_rvalid_i`  in  1  response valid; responses return in request order, latency ≥1.
- `Imem_rdata_i`  in  32  response instruction.
- `Instruction_o`  out  32  registered instruction to ID.
- `Inst_pc_o`  out  XLEN  PC of `Instruction_o`.
- `Inst_valid_o`  out  1  `Instruction_o` is real; 0 means the NOP is a bubble.
- `IF_tracker`  out  8  count of valid instructions issued, wraps modulo 256.

## Operation
- State:
  - `fetch_pc`: next address to request.
  - `resp_pc`: PC of the next accepted response.
  - FIFO of {pc, inst} with count `fcnt`.
  - `outstanding`: granted requests with no response yet.
  - `drop_cnt`: responses to discard.
  - Counter widths are clog2(FIFO_DEPTH)+1.
- Request: `Imem_req_o = Reset_n && !Redirect_valid_i && (fcnt + outstanding < FIFO_DEPTH)`.
  - On req&&gnt: `fetch_pc += 4`; `outstanding += 1`.
- Response on `Imem_rvalid_i`:
  - `outstanding -= 1`.
  - If `drop_cnt != 0`: `drop_cnt -= 1`; data discarded.
  - Otherwise push {`resp_pc`, `Imem_rdata_i`} and `resp_pc += 4`.
  - rvalid with `outstanding == 0` is a protocol violation and is ignored with no state change.
- Output, when not stalled:
  - If `!Stall_i` and FIFO non-empty: pop into `Instruction_o`/`Inst_pc_o`; `Inst_valid_o = 1`; `IF_tracker += 1`.
  - If `!Stall_i` and FIFO empty: `Instruction_o = NOP_INST`; `Inst_valid_o = 0`; `Inst_pc_o` holds.
- Output, when stalled: if `Stall_i`, all outputs and `IF_tracker` hold. No pop occurs, but pushes and requests continue.
- Redirect, which has priority over everything including `Stall_i`:
  - `fetch_pc` and `resp_pc` load the target.
  - FIFO is cleared.
  - `drop_cnt = outstanding` after this cycle's response (in-flight requests become stale). Stale responses whose data is discarded still decrement `outstanding`.
  - Output becomes NOP with `Inst_valid_o = 0`; `IF_tracker` holds.
  - A response arriving in the redirect cycle is dropped.
- Push and pop may occur in the same cycle; `fcnt` is unchanged. There is no FIFO bypass.
- Arithmetic: PC increments wrap modulo 2^XLEN. Pointers wrap modulo `FIFO_DEPTH`.

## Timing
- Reset values, while `Reset_n == 0` at an edge:
  - `fetch_pc = resp_pc = RESET_PC`
  - FIFO empty; all counters 0
  - `Instruction_o = NOP_INST`; `Inst_pc_o = 0`; `Inst_valid_o = 0`; `IF_tracker = 0`
  - `Imem_req_o = 0` combinationally during reset.
- Reset mid-operation discards all buffered and in-flight state. Responses arriving after reset release with `outstanding == 0` are ignored.
- Latency:
  - Grant in cycle t, rvalid in cycle c ≥ t+1.
  - Instruction is in the FIFO from c+1.
  - Visible on `Instruction_o` from c+2 if unstalled.
- With 1-cycle memory latency and no stalls, sustained throughput is one valid instruction per cycle.
- The first request after a redirect in cycle r is issued in r+1.
- Full condition: `fcnt + outstanding == FIFO_DEPTH` deasserts `Imem_req_o` in the same cycle. A pop re-enables it next cycle.

## Test plan
- Reset then run, 1-cycle memory, `FIFO_DEPTH=4`:
  - First valid output appears 3 cycles after the first grant, with PC 0x0.
  - PCs 0x0, 0x4, 0x8… follow one per cycle.
  - `IF_tracker` counts 1, 2, 3.
- Hold `Stall_i` 10 cycles with memory always granting:
  - At most 4 grants occur, then `Imem_req_o = 0`.
  - Output is held.
  - On release, 4 sequential instructions issue back-to-back with no gaps or duplicates.
- Redirect to 0x103 with 3 requests outstanding (3-cycle latency):
  - Next request address is 0x100.
  - The 3 stale responses are dropped.
  - First valid output has PC 0x100.
  - No pre-redirect instruction appears afterwards.
- Redirect asserted together with `Stall_i` and a FIFO holding 2 entries:
  - Output becomes NOP with `Inst_valid_o = 0` next cycle.
  - FIFO is empty; `IF_tracker` is unchanged.
- Random grant/rvalid gaps, random stalls and redirects against a reference PC model:
  - Valid outputs appear in program order with correct PCs.
  - `fcnt + outstanding ≤ FIFO_DEPTH` always.
  - `IF_tracker` wraps 255→0.
- Assert `Reset_n = 0` with 2 requests outstanding, then release:
  - Outputs return to their reset values.
  - Late responses are ignored.
  - First fetch address is `RESET_PC`.
